// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and entry type for the fetch buffer
//
// Purpose: default widths/depth for the fetch stage and the {pc, instr}
// entry layout queued between instruction memory and decode.
// Ports: none (package).
package fetch_pkg;

  localparam int ADDR_WIDTH_DEF  = 32;
  localparam int DATA_WIDTH_DEF  = 32;
  localparam int FETCH_DEPTH_DEF = 4;

  typedef struct packed {
    logic [ADDR_WIDTH_DEF-1:0] pc;
    logic [DATA_WIDTH_DEF-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer_if.sv
// rtl/fetch_buffer_if.sv - instruction memory and decode handshake bundle
//
// Purpose: groups the imem read channel and the decode valid/ready stream.
// Signals:
//   imem_req, imem_addr  fetch -> imem read request and address
//   imem_rdata           imem -> fetch, one cycle after imem_req
//   out_valid, out_instr, out_pc  fetch -> decode head entry
//   out_ready            decode -> fetch accept
// Modports: master (fetch_buffer side), slave (imem/decode side).
interface fetch_buffer_if
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_instr;
  logic [ADDR_WIDTH-1:0] out_pc;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc,
    input  imem_rdata, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc,
    output imem_rdata, out_ready
  );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with clear, head-of-queue read
//
// Purpose: DEPTH-entry queue; head_data always shows the entry at rd_ptr.
// Ports:
//   clk, rst     clock, synchronous active-high reset (clears storage too)
//   clear        drop all entries (pointers/count to zero), storage kept
//   push, push_data  write at wr_ptr
//   pop          advance rd_ptr
//   head_data    entry at rd_ptr
//   count        entries stored
// Callers guarantee no push when full and no pop when empty.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - instruction fetch stage with PC/instr queue
//
// Purpose: issues imem reads for pc_in, pairs each returned word with its
// PC, queues the pair and hands the head to decode; throttles the PC stage
// through pc_en and drops all buffered and in-flight work on flush.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   pc_in       current PC; also the read address
//   pc_en       PC stage advances this cycle (equals imem_req)
//   flush       redirect: discard queue and in-flight read
//   occupancy   entries currently queued
//   bus         imem read channel and decode stream (master side)
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = FETCH_DEPTH_DEF,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  output logic                  pc_en,
  input  logic                  flush,
  output logic [CNT_W-1:0]      occupancy,
  fetch_buffer_if.master        bus
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
  } entry_t;

  logic                  inflight;
  logic [ADDR_WIDTH-1:0] inflight_pc;
  logic [CNT_W-1:0]      count;
  logic [CNT_W:0]        pending;
  logic                  issue;
  logic                  push;
  logic                  pop;
  entry_t                wr_entry;
  entry_t                rd_entry;

  // Credit counts the in-flight read as occupied so its return always has
  // a free slot; a pop in the same cycle earns no credit.
  assign pending = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
  assign issue   = !rst && !flush && (pending < (CNT_W + 1)'(DEPTH));

  assign bus.imem_req  = issue;
  assign bus.imem_addr = pc_in;
  assign pc_en         = issue;

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc_in;
      end
    end
  end

  // Flush wins over both ends of the queue; the word returning during the
  // flush cycle belongs to the discarded path.
  assign push = inflight && !flush;
  assign pop  = bus.out_valid && bus.out_ready && !flush;

  assign wr_entry.pc    = inflight_pc;
  assign wr_entry.instr = bus.imem_rdata;

  sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (push),
    .push_data (wr_entry),
    .pop       (pop),
    .head_data (rd_entry),
    .count     (count)
  );

  assign bus.out_valid = (count != '0);
  assign bus.out_instr = rd_entry.instr;
  assign bus.out_pc    = rd_entry.pc;
  assign occupancy     = count;

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Instruction fetch stage directly downstream of the PC stage.
- Takes the current PC and issues a read to synchronous instruction memory (1-cycle read latency).
- Pairs each returned instruction with its PC and queues the pair in a DEPTH-entry FIFO.
- Presents the FIFO head to decode over a valid/ready handshake; throttles the PC with pc_en and drops all fetched/in-flight work on a redirect flush.

Parameters:
ADDR_WIDTH, 32, width of PC / instruction address
DATA_WIDTH, 32, instruction word width
DEPTH, 4, FIFO entries; power of 2, >= 2

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
pc_in  input  ADDR_WIDTH  current PC from PC stage
pc_en  output  1  PC stage advances to next PC this cycle when 1
imem_req  output  1  instruction memory read request
imem_addr  output  ADDR_WIDTH  read address, equals pc_in
imem_rdata  input  DATA_WIDTH  read data, valid exactly one cycle after imem_req=1
flush  input  1  taken jump/redirect; discard all buffered and in-flight fetches
out_valid  output  1  head entry valid for decode
out_ready  input  1  decode accepts head entry
out_instr  output  DATA_WIDTH  head instruction
out_pc  output  ADDR_WIDTH  PC of head instruction
occupancy  output  $clog2(DEPTH+1)  entries currently stored

Behaviour:
- Reset (rst=1 at edge):
  - count=0, rd/wr pointers=0, inflight=0, inflight_pc=0, all FIFO storage=0.
  - out_valid=0, out_instr=0, out_pc=0, occupancy=0.
  - imem_req and pc_en are forced 0 combinationally while rst=1.
  - Reset mid-operation discards everything, including in-flight data.
- Issue:
  - imem_req = !rst && !flush && (count + inflight < DEPTH).
  - No credit is taken for a same-cycle pop.
  - pc_en = imem_req; imem_addr = pc_in.
- Capture:
  - On an issue edge, inflight<=1 and inflight_pc<=pc_in; otherwise inflight<=0.
  - When inflight=1 and flush=0, {inflight_pc, imem_rdata} is written at wr_ptr on that edge.
- Output:
  - out_valid = (count != 0); out_instr/out_pc come from storage at rd_ptr.
  - Contents are don't-care when out_valid=0 but read back the last stored or reset values.
  - Pop = out_valid && out_ready && !flush.
- Count update:
  - count += push - pop; a push and a pop in the same cycle are both allowed, count unchanged.
  - Pointers wrap modulo DEPTH.
- Latency:
  - Request in cycle N: data returns in N+1, written at end of N+1, out_valid in N+2.
  - No bypass path.
  - With out_ready held at 1: one instruction per cycle, no bubbles.
- Overflow/underflow: impossible by the credit rule. Bench asserts count <= DEPTH and no push while full.
- Flush (priority over push, pop, issue):
  - On the edge: count<=0, pointers<=0, inflight<=0; returning imem_rdata is discarded.
  - imem_req=0 and pc_en=0 during the flush cycle.
  - The PC stage loads the redirect target itself in the flush cycle; target is on pc_in the next cycle and is fetched then.
  - out_valid=0 the cycle after flush.
- occupancy = count, registered.

Decomposition:
- fetch_pkg holds:
  - fetch_entry_t packed struct {pc, instr} sized from package constants ADDR_WIDTH_DEF=32 and DATA_WIDTH_DEF=32.
  - FETCH_DEPTH_DEF=4.
- One sub-module, sync_fifo:
  - Parameterised by entry type width and DEPTH.
  - Ports: clk, rst, clear, push, push_data, pop, head_data, count.
- fetch_buffer holds the issue/credit logic, in-flight tracking and flush control.

Test Plan:
- Reset: rst=1 for 3 cycles, pc_in=0, out_ready=1 -> imem_req=0, pc_en=0, out_valid=0, occupancy=0. First cycle after release: imem_req=1, imem_addr=0x0.
- Streaming: imem returns mem[a]=0xA000_0000|a, PC steps by 4, out_ready=1 -> out_valid first 2 cycles after first request. out_pc=0,4,8,... with out_instr=0xA0000000,0xA0000004,... one per cycle, no gaps.
- Backpressure: out_ready=0 from start -> exactly 4 requests (0,0x4,0x8,0xC), then imem_req=pc_en=0 and occupancy=4 held. Raise out_ready -> 0x0..0xC in order, then 0x10 continues; none lost or duplicated.
- Flush: 3 entries stored, 1 in flight, flush=1 one cycle, pc_in=0x100 after -> next cycle out_valid=0, occupancy=0, in-flight word dropped. Next delivered out_pc=0x100, 2 cycles after its request.
- Simultaneous: flush=1 with out_valid=1, out_ready=1 and returning data in the same cycle -> no pop counted, nothing written, occupancy=0 next cycle.
- Reset mid-run: rst=1 while full with one in flight -> identical to the reset scenario; no stale entry ever appears on out_pc.
